vga_scan_gen: RTL and testbench

- Raster timing generator for the 640x480 VGA path; the producing end of the `row`/`col` pixel-coordinate interface.
- Drives the pixel coordinates that the overlay and ROM readers consume (border, sprites) and the monitor sync lines.
- Divides the system clock down to a pixel-rate enable and walks horizontal and vertical counters through the visible area and blanking intervals.
- Emits line and frame boundary strobes for downstream per-line and per-frame state.

---
 rtl/vga_scan_gen.sv | 120 ++++++++++++
 tb/tb_vga_scan_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_gen.sv
// Raster timing generator for the 640x480 VGA path: pixel-rate enable,
// visible-area coordinates, active-low syncs and line/frame boundary strobes.
module vga_scan_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick,
    output logic [9:0] col,
    output logic [8:0] row,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_r;
    logic [DW-1:0] div_s;
    logic [HW-1:0] h_r;
    logic [HW-1:0] h_s;
    logic [VW-1:0] v_r;
    logic [VW-1:0] v_s;
    logic          run_r;
    logic          h_wrap_s;
    logic          v_wrap_s;
    logic          vis_s;

    // Next-state counters; run_r holds the divider for one cycle after reset
    // so that (0,0) is presented for a full CLK_DIV clks before the first tick.
    always_comb begin
        div_s    = div_r;
        h_s      = h_r;
        v_s      = v_r;
        h_wrap_s = 1'b0;
        v_wrap_s = 1'b0;
        if (run_r) begin
            if (div_r == DIV_LAST) begin
                div_s = '0;
            end else begin
                div_s = div_r + DW'(1);
            end
        end else begin
            div_s = div_r;
        end
        if (pix_tick) begin
            if (h_r == H_LAST) begin
                h_s      = '0;
                h_wrap_s = 1'b1;
                if (v_r == V_LAST) begin
                    v_s      = '0;
                    v_wrap_s = 1'b1;
                end else begin
                    v_s = v_r + VW'(1);
                end
            end else begin
                h_s = h_r + HW'(1);
            end
        end else begin
            h_s = h_r;
        end
        vis_s = (h_s < H_VIS) && (v_s < V_VIS);
    end

    // State and output registers; outputs decode the next-state counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r       <= '0;
            h_r         <= '0;
            v_r         <= '0;
            run_r       <= 1'b0;
            pix_tick    <= 1'b0;
            col         <= 10'd0;
            row         <= 9'd0;
            video_on    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_r       <= div_s;
            h_r         <= h_s;
            v_r         <= v_s;
            run_r       <= 1'b1;
            pix_tick    <= (div_s == DIV_LAST);
            video_on    <= vis_s;
            col         <= vis_s ? 10'(h_s) : 10'd0;
            row         <= vis_s ? 9'(v_s) : 9'd0;
            hsync       <= !((h_s >= HS_BEG) && (h_s < HS_END));
            vsync       <= !((v_s >= VS_BEG) && (v_s < VS_END));
            line_start  <= h_wrap_s;
            frame_start <= v_wrap_s;
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen: one default-size instance plus two
// reduced-timing instances (CLK_DIV 2 and 1) so full frames fit in the run.
module tb_vga_scan_gen;

    localparam int END_CYC = 33000;

    typedef struct {
        int         cyc;
        logic [9:0] col;
        logic [8:0] row;
        logic       vo;
        logic       hs;
        logic       vs;
        logic       pt;
    } vec_t;

    typedef struct {
        int   cyc;
        logic fs;
    } evt_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic       pt_a, pt_b, pt_c;
    logic [9:0] col_a, col_b, col_c;
    logic [8:0] row_a, row_b, row_c;
    logic       vo_a, vo_b, vo_c;
    logic       hs_a, hs_b, hs_c;
    logic       vs_a, vs_b, vs_c;
    logic       ls_a, ls_b, ls_c;
    logic       fs_a, fs_b, fs_c;

    vec_t vq [3][$];
    evt_t eq [3][$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = -1;
    bit   started = 1'b0;

    vga_scan_gen #(.CLK_DIV(2)) dut_a (
        .clk(clk), .reset(rst_a), .pix_tick(pt_a), .col(col_a), .row(row_a),
        .video_on(vo_a), .hsync(hs_a), .vsync(vs_a),
        .line_start(ls_a), .frame_start(fs_a));

    vga_scan_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(2)) dut_b (
        .clk(clk), .reset(rst_b), .pix_tick(pt_b), .col(col_b), .row(row_b),
        .video_on(vo_b), .hsync(hs_b), .vsync(vs_b),
        .line_start(ls_b), .frame_start(fs_b));

    vga_scan_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(1)) dut_c (
        .clk(clk), .reset(rst_c), .pix_tick(pt_c), .col(col_c), .row(row_c),
        .video_on(vo_c), .hsync(hs_c), .vsync(vs_c),
        .line_start(ls_c), .frame_start(fs_c));

    // Cycle 0 is the first cycle after the reset release edge.
    always @(posedge clk) begin
        if (started) cyc <= cyc + 1;
    end

    function automatic void pv(input int d, input int c, input int cl, input int rw,
                               input bit vo, input bit hs, input bit vs, input bit pt);
        vec_t e;
        e.cyc = c; e.col = cl[9:0]; e.row = rw[8:0];
        e.vo = vo; e.hs = hs; e.vs = vs; e.pt = pt;
        vq[d].push_back(e);
    endfunction

    function automatic void pe(input int d, input int c, input bit fs);
        evt_t e;
        e.cyc = c; e.fs = fs;
        eq[d].push_back(e);
    endfunction

    task automatic check(input int d, input logic [9:0] cl, input logic [8:0] rw,
                         input logic vo, input logic hs, input logic vs, input logic pt,
                         input logic ls, input logic fs);
        vec_t e;
        evt_t ev;
        if (vq[d].size() > 0 && vq[d][0].cyc == cyc) begin
            e = vq[d].pop_front();
            n_cmp++;
            if ({cl, rw, vo, hs, vs, pt} !== {e.col, e.row, e.vo, e.hs, e.vs, e.pt}) begin
                n_err++;
                $display("FAIL vec dut%0d cyc=%0d got col=%0d row=%0d vo=%b hs=%b vs=%b pt=%b want col=%0d row=%0d vo=%b hs=%b vs=%b pt=%b",
                         d, cyc, cl, rw, vo, hs, vs, pt, e.col, e.row, e.vo, e.hs, e.vs, e.pt);
            end
        end
        if (ls === 1'b1 || fs === 1'b1) begin
            n_cmp++;
            if (eq[d].size() == 0) begin
                n_err++;
                $display("FAIL strobe dut%0d cyc=%0d got ls=%b fs=%b want no strobe", d, cyc, ls, fs);
            end else begin
                ev = eq[d].pop_front();
                if (ev.cyc != cyc || fs !== ev.fs || ls !== 1'b1) begin
                    n_err++;
                    $display("FAIL strobe dut%0d got cyc=%0d ls=%b fs=%b want cyc=%0d ls=1 fs=%b",
                             d, cyc, ls, fs, ev.cyc, ev.fs);
                end
            end
        end
    endtask

    // Monitor: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        check(0, col_a, row_a, vo_a, hs_a, vs_a, pt_a, ls_a, fs_a);
        check(1, col_b, row_b, vo_b, hs_b, vs_b, pt_b, ls_b, fs_b);
        check(2, col_c, row_c, vo_c, hs_c, vs_c, pt_c, ls_c, fs_c);
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        for (int d = 0; d < 3; d++) pv(d, -1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Default timing, CLK_DIV=2: pixel p occupies cycles 2p and 2p+1.
        pv(0, 0, 0, 0, 1, 1, 1, 0);
        pv(0, 1, 0, 0, 1, 1, 1, 1);
        pv(0, 2, 1, 0, 1, 1, 1, 0);
        pv(0, 3, 1, 0, 1, 1, 1, 1);
        pv(0, 1279, 639, 0, 1, 1, 1, 1);
        pv(0, 1280, 0, 0, 0, 1, 1, 0);
        pv(0, 1311, 0, 0, 0, 1, 1, 1);
        pv(0, 1312, 0, 0, 0, 0, 1, 0);
        pv(0, 1503, 0, 0, 0, 0, 1, 1);
        pv(0, 1504, 0, 0, 0, 1, 1, 0);
        pv(0, 1600, 0, 1, 1, 1, 1, 0);
        pv(0, 32200, 100, 20, 1, 1, 1, 0);
        pv(0, 32201, 100, 20, 1, 1, 1, 1);
        pv(0, 32202, 101, 20, 1, 1, 1, 0);
        pv(0, 32239, 119, 20, 1, 1, 1, 1);
        pv(0, 32240, 120, 20, 1, 1, 1, 0);
        for (int n = 1; n <= 20; n++) pe(0, 1600 * n, 1'b0);

        // Small timing (H 8/2/3/2 = 15, V 4/1/2/1 = 8), CLK_DIV=2.
        pv(1, 0, 0, 0, 1, 1, 1, 0);
        pv(1, 1, 0, 0, 1, 1, 1, 1);
        pv(1, 2, 1, 0, 1, 1, 1, 0);
        pv(1, 15, 7, 0, 1, 1, 1, 1);
        pv(1, 16, 0, 0, 0, 1, 1, 0);
        pv(1, 20, 0, 0, 0, 0, 1, 0);
        pv(1, 25, 0, 0, 0, 0, 1, 1);
        pv(1, 26, 0, 0, 0, 1, 1, 0);
        pv(1, 30, 0, 1, 1, 1, 1, 0);
        pv(1, 36, 3, 1, 1, 1, 1, 0);
        pv(1, 99, 4, 3, 1, 1, 1, 1);
        pv(1, 122, 0, 0, 0, 1, 1, 0);
        pv(1, 150, 0, 0, 0, 1, 0, 0);
        pv(1, 179, 0, 0, 0, 1, 0, 1);
        pv(1, 180, 0, 0, 0, 1, 0, 0);
        pv(1, 210, 0, 0, 0, 1, 1, 0);
        pv(1, 240, 0, 0, 1, 1, 1, 0);
        for (int n = 1; n <= 1100; n++) pe(1, 30 * n, (n % 8) == 0);

        // Small timing, CLK_DIV=1; reset pulse inside both syncs at cycle 326.
        pv(2, 0, 0, 0, 1, 1, 1, 1);
        pv(2, 5, 5, 0, 1, 1, 1, 1);
        pv(2, 10, 0, 0, 0, 0, 1, 1);
        pv(2, 12, 0, 0, 0, 0, 1, 1);
        pv(2, 13, 0, 0, 0, 1, 1, 1);
        pv(2, 15, 0, 1, 1, 1, 1, 1);
        pv(2, 120, 0, 0, 1, 1, 1, 1);
        pv(2, 326, 0, 0, 0, 0, 0, 1);
        pv(2, 327, 0, 0, 0, 1, 1, 0);
        pv(2, 328, 0, 0, 1, 1, 1, 1);
        pv(2, 330, 2, 0, 1, 1, 1, 1);
        for (int n = 1; n <= 21; n++) pe(2, 15 * n, (n % 8) == 0);
        for (int n = 1; n <= 2178; n++) pe(2, 328 + 15 * n, (n % 8) == 0);

        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        started = 1'b1;

        wait (cyc == 326);
        #1 rst_c = 1'b1;
        @(posedge clk);
        #1 rst_c = 1'b0;

        wait (cyc == END_CYC);
        @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (vq[d].size() > 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pending_vec dut%0d got %0d unchecked want 0 (next cyc=%0d)",
                         d, vq[d].size(), vq[d][0].cyc);
            end
            if (eq[d].size() > 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pending_strobe dut%0d got %0d missing want 0 (next cyc=%0d)",
                         d, eq[d].size(), eq[d][0].cyc);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
